// File: rtl/mips_data_bus_bridge.sv
// Bridges a single-cycle MIPS data port onto an Avalon-MM bus with waitrequest.
// The CPU is frozen through its clock enable until each load/store has finished on the bus.
module mips_data_bus_bridge #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_clk_enable,
    output logic        cpu_clk_enable,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [3:0]  cpu_byte_enable,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        bus_error
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_avm_address;
    logic          r_avm_read;
    logic          r_avm_write;
    logic [3:0]    r_avm_byteenable;
    logic [31:0]   r_avm_writedata;
    logic [31:0]   r_cpu_readdata;
    logic          r_bus_error;

    logic w_req_raw;
    logic w_req;
    logic w_bus_ack;
    logic w_timeout;

    assign w_req_raw = cpu_data_read | cpu_data_write;
    assign w_req     = ext_clk_enable & w_req_raw;
    assign w_bus_ack = (r_state == BUS) & ~avm_waitrequest;
    // A slave that answers on the very last allowed cycle still wins over the watchdog.
    assign w_timeout = (r_state == BUS) & avm_waitrequest & (r_count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = BUS;
                end
            end
            BUS: begin
                if (w_bus_ack || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count          <= '0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_byteenable <= '0;
            r_avm_writedata  <= '0;
            r_cpu_readdata   <= '0;
            r_bus_error      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_avm_address    <= {cpu_data_address[31:2], 2'b00};
                        r_avm_byteenable <= cpu_byte_enable;
                        r_avm_writedata  <= cpu_data_writedata;
                        r_avm_write      <= cpu_data_write;
                        r_avm_read       <= ~cpu_data_write;
                        r_count          <= '0;
                    end
                end
                BUS: begin
                    if (w_bus_ack) begin
                        if (r_avm_read) begin
                            r_cpu_readdata <= avm_readdata;
                        end
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                    end else if (w_timeout) begin
                        if (r_avm_read) begin
                            r_cpu_readdata <= ERR_DATA;
                        end
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frozen from request detection until DONE, where the CPU retires the access.
    assign cpu_clk_enable = ext_clk_enable &
                            (((r_state == IDLE) & ~w_req_raw) | (r_state == DONE));

    assign avm_address       = r_avm_address;
    assign avm_read          = r_avm_read;
    assign avm_write         = r_avm_write;
    assign avm_byteenable    = r_avm_byteenable;
    assign avm_writedata     = r_avm_writedata;
    assign cpu_data_readdata = r_cpu_readdata;
    assign bus_error         = r_bus_error;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Directed self-checking bench for mips_data_bus_bridge (watchdog shortened to 8 cycles).
module tb_mips_data_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_clk_enable;
    logic        cpu_clk_enable;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        bus_error;

    int passCount = 0;
    int checkCount = 0;

    mips_data_bus_bridge #(.TIMEOUT(8), .ERR_DATA(32'hFFFFFFFF)) dut (
        .clk                (clk),
        .reset              (reset),
        .ext_clk_enable     (ext_clk_enable),
        .cpu_clk_enable     (cpu_clk_enable),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_byte_enable    (cpu_byte_enable),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_write          (avm_write),
        .avm_byteenable     (avm_byteenable),
        .avm_writedata      (avm_writedata),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest),
        .bus_error          (bus_error)
    );

    always #5 clk = ~clk;

    // Drives the CPU-side request inputs in one go.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_address   = addr;
        cpu_byte_enable    = be;
        cpu_data_writedata = wdata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ext_clk_enable = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkCount++;
        if ({avm_read, avm_write} !== 2'b00) $display("[TB] FAIL reset_strobes: got %b expected 00", {avm_read, avm_write});
        else passCount++;
        checkCount++;
        if ({avm_address, avm_byteenable, avm_writedata} !== 68'h0) $display("[TB] FAIL reset_bus: got %h/%h/%h expected all zero", avm_address, avm_byteenable, avm_writedata);
        else passCount++;
        checkCount++;
        if ({cpu_data_readdata, bus_error} !== 33'h0) $display("[TB] FAIL reset_cpu: got %h/%b expected 0/0", cpu_data_readdata, bus_error);
        else passCount++;
        checkCount++;
        if (cpu_clk_enable !== 1'b1) $display("[TB] FAIL reset_enable: got %b expected 1", cpu_clk_enable);
        else passCount++;
        reset = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        int readHigh = 0;
        int firstCe = -1;
        logic [31:0] seenAddr = 32'h0;
        logic [31:0] dataAtCe = 32'h0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            applyStimulus(k <= 2, 1'b0, 32'h1000_0006, 4'hF, 32'h0);
            #1;
            if (avm_read) begin
                readHigh++;
                seenAddr = avm_address;
            end
            if (cpu_clk_enable && firstCe < 0) begin
                firstCe = k;
                dataAtCe = cpu_data_readdata;
            end
        end
        checkCount++;
        if (readHigh !== 1) $display("[TB] FAIL zw_read_cycles: got %0d expected 1", readHigh);
        else passCount++;
        checkCount++;
        if (seenAddr !== 32'h1000_0004) $display("[TB] FAIL zw_address: got %h expected 10000004", seenAddr);
        else passCount++;
        checkCount++;
        if (firstCe !== 2) $display("[TB] FAIL zw_stall: got release at %0d expected 2", firstCe);
        else passCount++;
        checkCount++;
        if (dataAtCe !== 32'hDEADBEEF) $display("[TB] FAIL zw_readdata: got %h expected deadbeef", dataAtCe);
        else passCount++;
    endtask

    task automatic test_write_wait_states();
        int writeHigh = 0;
        int unstable = 0;
        int firstCe = -1;
        avm_readdata = 32'h5555_AAAA;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            avm_waitrequest = (k < 4);
            applyStimulus(1'b0, k <= 5, 32'h0000_0020, 4'b0011, 32'h1234_5678);
            #1;
            if (avm_write) begin
                writeHigh++;
                if (avm_address !== 32'h20 || avm_byteenable !== 4'b0011 || avm_writedata !== 32'h1234_5678 || avm_read !== 1'b0)
                    unstable++;
            end
            if (cpu_clk_enable && firstCe < 0) firstCe = k;
        end
        checkCount++;
        if (writeHigh !== 4) $display("[TB] FAIL wr_strobe_cycles: got %0d expected 4", writeHigh);
        else passCount++;
        checkCount++;
        if (unstable !== 0) $display("[TB] FAIL wr_stable: got %0d bad cycles expected 0", unstable);
        else passCount++;
        checkCount++;
        if (firstCe !== 5) $display("[TB] FAIL wr_stall: got release at %0d expected 5", firstCe);
        else passCount++;
        checkCount++;
        if (cpu_data_readdata !== 32'hDEADBEEF) $display("[TB] FAIL wr_keeps_readdata: got %h expected deadbeef", cpu_data_readdata);
        else passCount++;
    endtask

    task automatic test_read_write_collision();
        int readHigh = 0;
        int writeHigh = 0;
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            applyStimulus(k <= 2, k <= 2, 32'h0000_0047, 4'b1000, 32'hA5A5_0001);
            #1;
            if (avm_read) readHigh++;
            if (avm_write) writeHigh++;
        end
        checkCount++;
        if (readHigh !== 0) $display("[TB] FAIL rw_no_read: got %0d expected 0", readHigh);
        else passCount++;
        checkCount++;
        if (writeHigh !== 1) $display("[TB] FAIL rw_write_once: got %0d expected 1", writeHigh);
        else passCount++;
        checkCount++;
        if (avm_address !== 32'h44) $display("[TB] FAIL rw_address: got %h expected 00000044", avm_address);
        else passCount++;
    endtask

    task automatic test_passthrough();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        ext_clk_enable = 1'b0;
        #1;
        checkCount++;
        if (cpu_clk_enable !== 1'b0) $display("[TB] FAIL pass_low: got %b expected 0", cpu_clk_enable);
        else passCount++;
        @(negedge clk);
        ext_clk_enable = 1'b1;
        #1;
        checkCount++;
        if (cpu_clk_enable !== 1'b1) $display("[TB] FAIL pass_high: got %b expected 1", cpu_clk_enable);
        else passCount++;
    endtask

    task automatic test_gated_start();
        int earlyStrobe = 0;
        int earlyCe = 0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ext_clk_enable = 1'b0;
            applyStimulus(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
            #1;
            if (avm_read || avm_write) earlyStrobe++;
            if (cpu_clk_enable) earlyCe++;
        end
        checkCount++;
        if (earlyStrobe !== 0 || earlyCe !== 0) $display("[TB] FAIL gate_hold: got strobe %0d enable %0d expected 0 0", earlyStrobe, earlyCe);
        else passCount++;
        @(negedge clk);
        ext_clk_enable = 1'b1;
        @(negedge clk);
        #1;
        checkCount++;
        if (avm_read !== 1'b1 || avm_address !== 32'h200) $display("[TB] FAIL gate_start: got read %b addr %h expected 1 00000200", avm_read, avm_address);
        else passCount++;
        @(negedge clk);
        #1;
        checkCount++;
        if (cpu_clk_enable !== 1'b1 || cpu_data_readdata !== 32'hCAFE_F00D) $display("[TB] FAIL gate_done: got enable %b data %h expected 1 cafef00d", cpu_clk_enable, cpu_data_readdata);
        else passCount++;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_timeout();
        int readHigh = 0;
        int firstCe = -1;
        logic [31:0] dataAtCe = 32'h0;
        logic errAtCe = 1'b0;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            applyStimulus(k <= 9, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
            #1;
            if (avm_read) readHigh++;
            if (cpu_clk_enable && firstCe < 0) begin
                firstCe = k;
                dataAtCe = cpu_data_readdata;
                errAtCe = bus_error;
            end
        end
        checkCount++;
        if (readHigh !== 8) $display("[TB] FAIL to_strobe_cycles: got %0d expected 8", readHigh);
        else passCount++;
        checkCount++;
        if (firstCe !== 9) $display("[TB] FAIL to_release: got %0d expected 9", firstCe);
        else passCount++;
        checkCount++;
        if (dataAtCe !== 32'hFFFFFFFF || errAtCe !== 1'b1) $display("[TB] FAIL to_error: got data %h err %b expected ffffffff 1", dataAtCe, errAtCe);
        else passCount++;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0000_1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(k <= 2, 1'b0, 32'h0000_0090, 4'hF, 32'h0);
        end
        #1;
        checkCount++;
        if (bus_error !== 1'b1 || cpu_data_readdata !== 32'h0000_1111) $display("[TB] FAIL to_sticky: got err %b data %h expected 1 00001111", bus_error, cpu_data_readdata);
        else passCount++;
    endtask

    task automatic test_reset_mid_bus();
        avm_waitrequest = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        @(negedge clk);
        #1;
        checkCount++;
        if (avm_read !== 1'b1) $display("[TB] FAIL rst_mid_pre: got read %b expected 1", avm_read);
        else passCount++;
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        reset = 1'b1;
        #1;
        checkCount++;
        if ({avm_read, avm_write, bus_error} !== 3'b000 || cpu_data_readdata !== 32'h0) $display("[TB] FAIL rst_mid_clear: got rd %b wr %b err %b data %h expected 0 0 0 0", avm_read, avm_write, bus_error, cpu_data_readdata);
        else passCount++;
        checkCount++;
        if (cpu_clk_enable !== 1'b1) $display("[TB] FAIL rst_mid_idle: got enable %b expected 1", cpu_clk_enable);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait_states();
        test_read_write_collision();
        test_passthrough();
        test_gated_start();
        test_timeout();
        test_reset_mid_bus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
